// File: rtl/wbaddr_guard_pkg.sv
// Shared types for the MMU-to-RAM bus guard: FSM encoding and the Wishbone request payload.
package wbaddr_guard_pkg;
  localparam int WB_AW = 30;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_ABORT = 2'd2
  } gstate_t;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
    logic [WB_SW-1:0] sel;
  } wb_req_t;
endpackage

// File: rtl/wbaddr_guard_if.sv
// Upstream pipelined Wishbone port between the MMU (master) and the guard (slave).
interface wbaddr_guard_if;
  import wbaddr_guard_pkg::*;

  logic             cyc;
  logic             stb;
  wb_req_t          req;
  logic             stall;
  logic             ack;
  logic             err;
  logic [WB_DW-1:0] rdata;

  modport master (output cyc, stb, req, input stall, ack, err, rdata);
  modport slave  (input cyc, stb, req, output stall, ack, err, rdata);
endinterface

// File: rtl/wbaddr_guard_timeout.sv
// Saturating idle-cycle counter; o_expired holds while the count sits at its maximum.
module wb_timeout #(
  parameter int LGTO = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  logic [LGTO-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr)
      r_cnt <= '0;
    else if (i_en && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt == '1);
endmodule

// File: rtl/wbaddr_guard.sv
// Address-window / timeout guard between the MMU physical port and on-chip RAM.
// Out-of-window strobes and stuck transactions are answered with a one-cycle bus error.
module wbaddr_guard
  import wbaddr_guard_pkg::*;
#(
  parameter int                 AW    = WB_AW,
  parameter int                 MAW   = 15,
  parameter logic [AW-MAW-1:0]  BASE  = 1,
  parameter int                 LGTO  = 8,
  parameter int                 LGOUT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  wbaddr_guard_if.slave     wb,
  output logic              o_mem_cyc,
  output logic              o_mem_stb,
  output logic              o_mem_we,
  output logic [MAW-1:0]    o_mem_addr,
  output logic [WB_DW-1:0]  o_mem_data,
  output logic [WB_SW-1:0]  o_mem_sel,
  input  logic              i_mem_ack,
  input  logic              i_mem_stall,
  input  logic [WB_DW-1:0]  i_mem_data,
  output logic [AW-1:0]     o_fault_addr,
  output logic              o_fault_to,
  output logic              o_fault_vld
);
  gstate_t          r_state;
  logic             r_err;
  logic [LGOUT-1:0] r_out, r_wptr;
  logic [AW-1:0]    r_oq [2**LGOUT];
  logic [AW-1:0]    r_fault_addr;
  logic             r_fault_to, r_fault_vld;

  logic [AW-1:0]    w_addr;
  logic [LGOUT-1:0] w_old_idx;
  logic w_inwin, w_full, w_out_nz, w_acc, w_ack, w_dec, w_bad;
  logic w_expired, w_to, w_fault, w_to_clr;

  assign w_addr    = wb.req.addr;
  assign w_inwin   = (w_addr[AW-1:MAW] == BASE);
  assign w_full    = (r_out == '1);
  assign w_out_nz  = (r_out != '0);

  // r_err gates cyc in the pulse cycle so the RAM is abandoned immediately
  assign o_mem_cyc = wb.cyc && (r_state != S_ABORT) && !r_err;
  assign o_mem_stb = o_mem_cyc && wb.stb && w_inwin && !w_full;
  assign o_mem_we   = wb.req.we;
  assign o_mem_addr = w_addr[MAW-1:0];
  assign o_mem_data = wb.req.data;
  assign o_mem_sel  = wb.req.sel;

  assign w_bad = o_mem_cyc && wb.stb && !w_inwin && !w_full;
  assign w_acc = o_mem_stb && !i_mem_stall;
  assign w_ack = o_mem_cyc && i_mem_ack;
  assign w_dec = w_ack && (w_out_nz || w_acc);

  assign wb.stall = !o_mem_cyc || w_full || (w_inwin && i_mem_stall);
  assign wb.ack   = w_ack;
  assign wb.rdata = i_mem_data;
  assign wb.err   = r_err;

  assign w_to_clr = !o_mem_cyc || w_ack || w_acc || !w_out_nz;
  assign w_to     = o_mem_cyc && w_out_nz && w_expired && !w_ack && !w_acc;
  assign w_fault  = w_bad || w_to;

  wb_timeout #(.LGTO(LGTO)) u_to (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (w_to_clr),
    .i_en      (w_out_nz),
    .o_expired (w_expired)
  );

  // Outstanding addresses in issue order; the oldest sits r_out entries behind the write pointer
  assign w_old_idx = r_wptr - r_out;

  always_ff @(posedge i_clk) begin
    if (w_acc)
      r_oq[r_wptr] <= w_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_err        <= 1'b0;
      r_out        <= '0;
      r_wptr       <= '0;
      r_fault_addr <= '0;
      r_fault_to   <= 1'b0;
      r_fault_vld  <= 1'b0;
    end else begin
      r_err <= w_fault;

      if (!wb.cyc)
        r_state <= S_IDLE;
      else if (w_fault)
        r_state <= S_ABORT;
      else if (r_state == S_IDLE)
        r_state <= S_BUSY;

      if (!wb.cyc || w_fault)
        r_out <= '0;
      else if (w_acc && !w_dec)
        r_out <= r_out + 1'b1;
      else if (w_dec && !w_acc)
        r_out <= r_out - 1'b1;

      if (w_acc)
        r_wptr <= r_wptr + 1'b1;

      if (w_fault && !r_fault_vld) begin
        r_fault_vld  <= 1'b1;
        r_fault_to   <= !w_bad;
        r_fault_addr <= w_bad ? w_addr : r_oq[w_old_idx];
      end
    end
  end

  assign o_fault_addr = r_fault_addr;
  assign o_fault_to   = r_fault_to;
  assign o_fault_vld  = r_fault_vld;
endmodule

// File: tb/tb_wbaddr_guard.sv
// Directed bench for wbaddr_guard: expected acks/errs go into a scoreboard queue that a
// negedge monitor drains; cycle-exact properties are checked inline.
module tb_wbaddr_guard;
  import wbaddr_guard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wbaddr_guard_if wb();

  logic        mem_cyc, mem_stb, mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_data, mem_rdata;
  logic [3:0]  mem_sel;
  logic        mem_ack, mem_stall;
  logic [29:0] fault_addr;
  logic        fault_to, fault_vld;

  wbaddr_guard dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .wb           (wb),
    .o_mem_cyc    (mem_cyc),
    .o_mem_stb    (mem_stb),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_data   (mem_data),
    .o_mem_sel    (mem_sel),
    .i_mem_ack    (mem_ack),
    .i_mem_stall  (mem_stall),
    .i_mem_data   (mem_rdata),
    .o_fault_addr (fault_addr),
    .o_fault_to   (fault_to),
    .o_fault_vld  (fault_vld)
  );

  typedef struct {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every upstream ack/err must match the next queued expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (wb.ack === 1'b1 || wb.err === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: ack=%0b err=%0b, want nothing (t=%0t)", wb.ack, wb.err, $time);
      end else begin
        e = sb.pop_front();
        chk("sb_kind", {62'd0, wb.err, wb.ack}, e.is_err ? 64'd2 : 64'd1);
        if (!e.is_err)
          chk("sb_data", {32'd0, wb.rdata}, {32'd0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic [29:0] a);
    wb.cyc      = cyc;
    wb.stb      = stb;
    wb.req.we   = 1'b0;
    wb.req.addr = a;
    wb.req.data = 32'd0;
    wb.req.sel  = 4'hF;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 30'd0);
    mem_ack = 1'b0;
    mem_stall = 1'b0;
    step;
    step;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 30'd0);
    mem_ack = 1'b0;
    mem_stall = 1'b0;
    mem_rdata = 32'd0;
    step;
    settle;
    chk("rst_mem_cyc", mem_cyc, 0);
    chk("rst_err", wb.err, 0);
    chk("rst_fault_vld", fault_vld, 0);
    chk("rst_fault_addr", fault_addr, 0);
    chk("rst_fault_to", fault_to, 0);
    chk("rst_out", dut.r_out, 0);
    step;
    rst = 1'b0;
    step;

    // 1: in-window read, then a write checking pass-through
    drive(1'b1, 1'b1, 30'h0000_8004);
    settle;
    chk("t1_mem_stb", mem_stb, 1);
    chk("t1_mem_addr", mem_addr, 15'h0004);
    chk("t1_stall", wb.stall, 0);
    step;
    drive(1'b1, 1'b0, 30'h0000_8004);
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b0, 32'hDEAD_BEEF});
    settle;
    chk("t1_ack", wb.ack, 1);
    step;
    mem_ack = 1'b0;
    drive(1'b1, 1'b1, 30'h0000_8005);
    wb.req.we = 1'b1;
    wb.req.data = 32'h1234_5678;
    wb.req.sel = 4'b0011;
    settle;
    chk("t1_we", mem_we, 1);
    chk("t1_waddr", mem_addr, 15'h0005);
    chk("t1_wdata", mem_data, 32'h1234_5678);
    chk("t1_wsel", mem_sel, 4'b0011);
    step;
    drive(1'b1, 1'b0, 30'h0000_8005);
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_0000;
    sb.push_back('{1'b0, 32'h0000_0000});
    step;
    mem_ack = 1'b0;
    settle;
    chk("t1_no_err", wb.err, 0);
    chk("t1_no_fault", fault_vld, 0);
    step;
    drive(1'b0, 1'b0, 30'd0);
    step;

    // 2: out-of-window strobe accepted with zero wait, err one cycle later, then stalled
    drive(1'b1, 1'b1, 30'h0001_0000);
    settle;
    chk("t2_mem_stb", mem_stb, 0);
    chk("t2_stall", wb.stall, 0);
    chk("t2_err_early", wb.err, 0);
    sb.push_back('{1'b1, 32'd0});
    step;
    drive(1'b1, 1'b1, 30'h0000_8004);
    settle;
    chk("t2_err", wb.err, 1);
    chk("t2_mem_cyc", mem_cyc, 0);
    chk("t2_stall_abort", wb.stall, 1);
    chk("t2_fault_vld", fault_vld, 1);
    chk("t2_fault_addr", fault_addr, 30'h0001_0000);
    chk("t2_fault_to", fault_to, 0);
    step;
    mem_ack = 1'b1;
    settle;
    chk("t2_err_pulse", wb.err, 0);
    chk("t2_stall_hold", wb.stall, 1);
    chk("t2_mem_stb_hold", mem_stb, 0);
    chk("t2_ack_blocked", wb.ack, 0);
    step;
    mem_ack = 1'b0;
    drive(1'b0, 1'b0, 30'd0);
    step;
    // a second fault must not overwrite the latch
    drive(1'b1, 1'b1, 30'h0002_0000);
    sb.push_back('{1'b1, 32'd0});
    step;
    drive(1'b1, 1'b0, 30'h0002_0000);
    settle;
    chk("t2_err2", wb.err, 1);
    chk("t2_latch_hold", fault_addr, 30'h0001_0000);
    step;
    drive(1'b0, 1'b0, 30'd0);
    step;
    do_reset;

    // 3: RAM never acks. Accept in cycle A; timer is 0 in A+1 and reaches 255 in A+256
    // after 255 ack-less cycles, so err shows in A+257 together with mem_cyc dropping.
    drive(1'b1, 1'b1, 30'h0000_8010);
    settle;
    chk("t3_mem_stb", mem_stb, 1);
    step;
    drive(1'b1, 1'b0, 30'h0000_8010);
    repeat (255) step;
    settle;
    chk("t3_err_not_yet", wb.err, 0);
    chk("t3_cyc_before", mem_cyc, 1);
    sb.push_back('{1'b1, 32'd0});
    step;
    settle;
    chk("t3_err", wb.err, 1);
    chk("t3_cyc_drop", mem_cyc, 0);
    chk("t3_fault_to", fault_to, 1);
    chk("t3_fault_addr", fault_addr, 30'h0000_8010);
    chk("t3_fault_vld", fault_vld, 1);
    step;
    drive(1'b0, 1'b0, 30'd0);
    step;
    do_reset;

    // 4: 16 back-to-back reads; 15 outstanding fills the guard
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b1, 30'h0000_8000 + 30'(i));
      settle;
      chk("t4_stall_pre", wb.stall, 0);
      step;
    end
    drive(1'b1, 1'b1, 30'h0000_800F);
    settle;
    chk("t4_stall_full", wb.stall, 1);
    chk("t4_stb_full", mem_stb, 0);
    step;
    settle;
    chk("t4_stall_full2", wb.stall, 1);
    step;
    mem_ack = 1'b1;
    mem_rdata = 32'hA000_0000;
    sb.push_back('{1'b0, 32'hA000_0000});
    settle;
    chk("t4_stall_on_ack", wb.stall, 1);
    step;
    mem_ack = 1'b0;
    settle;
    chk("t4_release", wb.stall, 0);
    chk("t4_stb16", mem_stb, 1);
    chk("t4_addr16", mem_addr, 15'h000F);
    step;
    drive(1'b1, 1'b0, 30'h0000_800F);
    for (int j = 1; j < 16; j++) begin
      mem_ack = 1'b1;
      mem_rdata = 32'hA000_0000 + 32'(j);
      sb.push_back('{1'b0, 32'hA000_0000 + 32'(j)});
      step;
    end
    mem_ack = 1'b0;
    settle;
    chk("t4_out_zero", dut.r_out, 0);
    chk("t4_no_err", wb.err, 0);
    chk("t4_no_fault", fault_vld, 0);
    step;
    drive(1'b0, 1'b0, 30'd0);
    step;

    // 5: bad strobe in the same cycle as the ack for the prior good read
    drive(1'b1, 1'b1, 30'h0000_8020);
    step;
    drive(1'b1, 1'b1, 30'h0001_0040);
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    sb.push_back('{1'b0, 32'h5555_AAAA});
    sb.push_back('{1'b1, 32'd0});
    settle;
    chk("t5_ack", wb.ack, 1);
    chk("t5_stall", wb.stall, 0);
    chk("t5_err_early", wb.err, 0);
    step;
    mem_ack = 1'b0;
    drive(1'b1, 1'b0, 30'h0001_0040);
    settle;
    chk("t5_err", wb.err, 1);
    chk("t5_fault_addr", fault_addr, 30'h0001_0040);
    chk("t5_fault_to", fault_to, 0);
    step;
    drive(1'b0, 1'b0, 30'd0);
    step;

    // 6: reset with 3 outstanding; master resets too so cyc drops with it
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 30'h0000_8000 + 30'(i));
      step;
    end
    drive(1'b1, 1'b0, 30'h0000_8002);
    settle;
    chk("t6_out3", dut.r_out, 3);
    rst = 1'b1;
    step;
    drive(1'b0, 1'b0, 30'd0);
    mem_ack = 1'b1;
    settle;
    chk("t6_mem_cyc", mem_cyc, 0);
    chk("t6_err", wb.err, 0);
    chk("t6_out", dut.r_out, 0);
    chk("t6_tmr", dut.u_to.r_cnt, 0);
    chk("t6_fault_vld", fault_vld, 0);
    chk("t6_fault_addr", fault_addr, 0);
    chk("t6_late_ack", wb.ack, 0);
    step;
    rst = 1'b0;
    mem_ack = 1'b0;
    step;
    step;

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
